// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 decode constants, ALU codes and control-bit types
// Purpose: opcode/funct3/funct7 encodings and 3-bit ALU control codes used by the
//          ID/EX stage and its decoder.
// Ports:   none (package).
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  typedef enum logic [1:0] {
    OP2_RS2   = 2'd0,
    OP2_IMM   = 2'd1,
    OP2_SHAMT = 2'd2
  } op2_sel_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: upstream handshake+operands, downstream results
// Purpose: groups every non-clock/reset signal of id_ex_stage.
// Ports:   none; modport slave = the stage, modport master = the ID/EX/hazard environment.
//          Upstream: in_valid_i/in_ready_o, opcode_i, funct3_i, funct7_i, rs1_data_i,
//          rs2_data_i, imm_i, rd_addr_i, flush_i.
//          Downstream: out_valid_o/out_ready_i, alu_ctrl_o, data1_o, data2_o, rs2_data_o,
//          rd_addr_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o, illegal_o,
//          flush_cnt_o.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [6:0]       opcode_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [XLEN-1:0]  imm_i;
  logic [4:0]       rd_addr_i;
  logic             flush_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0]       alu_ctrl_o;
  logic [XLEN-1:0]  data1_o;
  logic [XLEN-1:0]  data2_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic [4:0]       rd_addr_o;
  logic             regwrite_o;
  logic             memread_o;
  logic             memwrite_o;
  logic             memtoreg_o;
  logic             branch_o;
  logic             illegal_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  in_valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i,
           rd_addr_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_ctrl_o, data1_o, data2_o, rs2_data_o, rd_addr_o,
           regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o, illegal_o, flush_cnt_o
  );

  modport master (
    output in_valid_i, opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i,
           rd_addr_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_ctrl_o, data1_o, data2_o, rs2_data_o, rd_addr_o,
           regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o, illegal_o, flush_cnt_o
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational opcode/funct3/funct7 decode for the ID/EX stage
// Purpose: produces ALU control code, operand-2 select, control bits and illegal flag.
// Ports:   i_opcode[6:0], i_funct3[2:0], i_funct7[6:0] in;
//          o_alu_ctrl[2:0], o_op2_sel, o_ctrl, o_illegal out.
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_ctrl,
  output op2_sel_e   o_op2_sel,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = ALU_NOP;
    o_op2_sel  = OP2_RS2;
    o_ctrl     = '0;
    o_illegal  = 1'b0;

    case (i_opcode)
      OP_R: begin
        o_ctrl.regwrite = 1'b1;
        if (i_funct7 == F7_BASE) begin
          case (i_funct3)
            F3_AND:     o_alu_ctrl = ALU_AND;
            F3_XOR:     o_alu_ctrl = ALU_XOR;
            F3_SLL:     o_alu_ctrl = ALU_SLL;
            F3_ADD_SUB: o_alu_ctrl = ALU_ADD;
            default:    o_illegal  = 1'b1;
          endcase
        end else if (i_funct7 == F7_ALT && i_funct3 == F3_ADD_SUB) begin
          o_alu_ctrl = ALU_SUB;
        end else if (i_funct7 == F7_MULDIV && i_funct3 == F3_ADD_SUB) begin
          o_alu_ctrl = ALU_MUL;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_I: begin
        o_ctrl.regwrite = 1'b1;
        // addi ignores funct7: those bits belong to the immediate
        if (i_funct3 == F3_ADD_SUB) begin
          o_alu_ctrl = ALU_ADD;
          o_op2_sel  = OP2_IMM;
        end else if (i_funct3 == F3_SRA && i_funct7 == F7_ALT) begin
          o_alu_ctrl = ALU_SRAI;
          o_op2_sel  = OP2_SHAMT;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        o_alu_ctrl      = ALU_ADD;
        o_op2_sel       = OP2_IMM;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      OP_STORE: begin
        o_alu_ctrl      = ALU_ADD;
        o_op2_sel       = OP2_IMM;
        o_ctrl.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        o_alu_ctrl    = ALU_SUB;
        o_ctrl.branch = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase

    // Illegal encodings still flow down the pipe, but as a harmless nop
    if (o_illegal) begin
      o_alu_ctrl = ALU_NOP;
      o_op2_sel  = OP2_RS2;
      o_ctrl     = '0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with valid/ready, stall and flush
// Purpose: decodes the ALU control, selects operand 2 and registers operands and
//          control bits for EX; counts valid instructions killed by flush (saturating).
// Ports:   clk_i  in  clock, rising edge
//          rst_i  in  synchronous reset, active-high
//          bus    id_ex_stage_if.slave (upstream handshake/operands, downstream results)
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);

  logic [2:0]       w_alu_ctrl;
  op2_sel_e         w_op2_sel;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic [XLEN-1:0]  w_op2;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_consume;
  logic             w_cnt_max;

  logic             r_out_valid;
  logic [2:0]       r_alu_ctrl;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_data2;
  logic [XLEN-1:0]  r_rs2_data;
  logic [4:0]       r_rd_addr;
  ctrl_t            r_ctrl;
  logic             r_illegal;
  logic [CNT_W-1:0] r_flush_cnt;

  alu_ctrl_decode u_decode (
    .i_opcode   (bus.opcode_i),
    .i_funct3   (bus.funct3_i),
    .i_funct7   (bus.funct7_i),
    .o_alu_ctrl (w_alu_ctrl),
    .o_op2_sel  (w_op2_sel),
    .o_ctrl     (w_ctrl),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_op2 = bus.rs2_data_i;
    case (w_op2_sel)
      OP2_IMM:   w_op2 = bus.imm_i;
      OP2_SHAMT: w_op2 = {{(XLEN-5){1'b0}}, bus.imm_i[4:0]};
      default:   w_op2 = bus.rs2_data_i;
    endcase
  end

  assign w_in_ready = !bus.flush_i && (!r_out_valid || bus.out_ready_i);
  assign w_accept   = bus.in_valid_i && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready_i;
  assign w_cnt_max  = &r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= ALU_NOP;
      r_data1     <= '0;
      r_data2     <= '0;
      r_rs2_data  <= '0;
      r_rd_addr   <= '0;
      r_ctrl      <= '0;
      r_illegal   <= 1'b0;
      r_flush_cnt <= '0;
    end else if (bus.flush_i) begin
      // Bubble: operands are left as-is, only validity and side-effecting bits die
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= ALU_NOP;
      r_ctrl      <= '0;
      if (r_out_valid && !w_cnt_max) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_ctrl  <= w_alu_ctrl;
      r_data1     <= bus.rs1_data_i;
      r_data2     <= w_op2;
      r_rs2_data  <= bus.rs2_data_i;
      r_rd_addr   <= bus.rd_addr_i;
      r_ctrl      <= w_ctrl;
      r_illegal   <= w_illegal;
    end else if (w_consume) begin
      // memtoreg is only a mux select, so it is left holding with the operands
      r_out_valid     <= 1'b0;
      r_alu_ctrl      <= ALU_NOP;
      r_ctrl.regwrite <= 1'b0;
      r_ctrl.memread  <= 1'b0;
      r_ctrl.memwrite <= 1'b0;
      r_ctrl.branch   <= 1'b0;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.alu_ctrl_o  = r_alu_ctrl;
  assign bus.data1_o     = r_data1;
  assign bus.data2_o     = r_data2;
  assign bus.rs2_data_o  = r_rs2_data;
  assign bus.rd_addr_o   = r_rd_addr;
  assign bus.regwrite_o  = r_ctrl.regwrite;
  assign bus.memread_o   = r_ctrl.memread;
  assign bus.memwrite_o  = r_ctrl.memwrite;
  assign bus.memtoreg_o  = r_ctrl.memtoreg;
  assign bus.branch_o    = r_ctrl.branch;
  assign bus.illegal_o   = r_illegal;
  assign bus.flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic [31:0] d2;
    logic [4:0]  ctrl;   // {regwrite, memread, memwrite, memtoreg, branch}
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                              logic [4:0] rd, logic [2:0] alu, logic [31:0] d2,
                              logic [4:0] ctrl, logic ill);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.rd = rd; v.alu = alu; v.d2 = d2; v.ctrl = ctrl; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid_i = 1'b1;
    bus.opcode_i   = v.op;
    bus.funct3_i   = v.f3;
    bus.funct7_i   = v.f7;
    bus.rs1_data_i = v.rs1;
    bus.rs2_data_i = v.rs2;
    bus.imm_i      = v.imm;
    bus.rd_addr_i  = v.rd;
  endtask

  function automatic logic [4:0] ctrl_bits();
    return {bus.regwrite_o, bus.memread_o, bus.memwrite_o, bus.memtoreg_o, bus.branch_o};
  endfunction

  task automatic check_out(input vec_t v);
    chk({v.name, ".out_valid"}, 32'(bus.out_valid_o), 32'd1);
    chk({v.name, ".alu_ctrl"},  32'(bus.alu_ctrl_o),  32'(v.alu));
    chk({v.name, ".data1"},     bus.data1_o,          v.rs1);
    chk({v.name, ".data2"},     bus.data2_o,          v.d2);
    chk({v.name, ".rs2_data"},  bus.rs2_data_o,       v.rs2);
    chk({v.name, ".rd_addr"},   32'(bus.rd_addr_o),   32'(v.rd));
    chk({v.name, ".ctrl"},      32'(ctrl_bits()),     32'(v.ctrl));
    chk({v.name, ".illegal"},   32'(bus.illegal_o),   32'(v.ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc;

    // Illegal rows use rs2 == imm so the operand-2 check does not depend on mux choice
    vecs.push_back(mk("add",   7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'hFFFF_FFF9, 32'h123, 5'd3, 3'b100, 32'hFFFF_FFF9, 5'b10000, 1'b0));
    vecs.push_back(mk("sub",   7'b0110011, 3'b000, 7'b0100000, 32'd100, 32'd30, 32'h0, 5'd4, 3'b101, 32'd30, 5'b10000, 1'b0));
    vecs.push_back(mk("and",   7'b0110011, 3'b111, 7'b0000000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 5'd5, 3'b001, 32'h0FF0_0FF0, 5'b10000, 1'b0));
    vecs.push_back(mk("xor",   7'b0110011, 3'b100, 7'b0000000, 32'd1, 32'd3, 32'h0, 5'd6, 3'b010, 32'd3, 5'b10000, 1'b0));
    vecs.push_back(mk("sll",   7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'd4, 32'h0, 5'd7, 3'b011, 32'd4, 5'b10000, 1'b0));
    vecs.push_back(mk("mul",   7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'h0, 5'd8, 3'b110, 32'd7, 5'b10000, 1'b0));
    vecs.push_back(mk("addi",  7'b0010011, 3'b000, 7'b1010101, 32'd10, 32'hAAAA, 32'hFFFF_FFF0, 5'd9, 3'b100, 32'hFFFF_FFF0, 5'b10000, 1'b0));
    vecs.push_back(mk("srai",  7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'hBBBB, 32'h0000_0423, 5'd10, 3'b111, 32'h0000_0003, 5'b10000, 1'b0));
    vecs.push_back(mk("lw",    7'b0000011, 3'b010, 7'b0000000, 32'h1000, 32'hCCCC, 32'd8, 5'd11, 3'b100, 32'd8, 5'b11010, 1'b0));
    vecs.push_back(mk("sw",    7'b0100011, 3'b010, 7'b0000000, 32'h2000, 32'hDEAD_BEEF, 32'h0C, 5'd0, 3'b100, 32'h0C, 5'b00100, 1'b0));
    vecs.push_back(mk("ill7f", 7'b1111111, 3'b000, 7'b0000000, 32'd1, 32'h55, 32'h55, 5'd12, 3'b000, 32'h55, 5'b00000, 1'b1));
    vecs.push_back(mk("slt",   7'b0110011, 3'b010, 7'b0000000, 32'd2, 32'h66, 32'h66, 5'd13, 3'b000, 32'h66, 5'b00000, 1'b1));
    vecs.push_back(mk("srli",  7'b0010011, 3'b101, 7'b0000000, 32'd3, 32'h77, 32'h77, 5'd14, 3'b000, 32'h77, 5'b00000, 1'b1));
    vecs.push_back(mk("sub_f3",7'b0110011, 3'b001, 7'b0100000, 32'd4, 32'h88, 32'h88, 5'd15, 3'b000, 32'h88, 5'b00000, 1'b1));
    vecs.push_back(mk("beq",   7'b1100011, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'h10, 5'd0, 3'b101, 32'd9, 5'b00001, 1'b0));

    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.opcode_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
    bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.imm_i = '0; bus.rd_addr_i = '0;
    tick(); tick();

    // reset state
    chk("rst.out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst.alu_ctrl",  32'(bus.alu_ctrl_o),  32'd0);
    chk("rst.data1",     bus.data1_o,          32'd0);
    chk("rst.data2",     bus.data2_o,          32'd0);
    chk("rst.ctrl",      32'(ctrl_bits()),     32'd0);
    chk("rst.flush_cnt", 32'(bus.flush_cnt_o), 32'd0);
    chk("rst.in_ready",  32'(bus.in_ready_o),  32'd1);
    rst = 1'b0;

    // back-to-back decode table, EX always ready
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check_out(vecs[i]);
    end

    // EX consumes with nothing new: bubble, operands hold
    bus.in_valid_i = 1'b0;
    tick();
    chk("drain.out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("drain.alu_ctrl",  32'(bus.alu_ctrl_o),  32'd0);
    chk("drain.branch",    32'(bus.branch_o),    32'd0);
    chk("drain.data1",     bus.data1_o,          32'd9);

    // stall for 3 cycles with a new instruction pending
    va = vecs[0]; va.rs1 = 32'd11;
    vb = vecs[1]; vb.rs1 = 32'd22;
    drive(va);
    tick();
    chk("stall.load_a", bus.data1_o, 32'd11);
    drive(vb);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.in_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
      chk("stall.out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("stall.data1",     bus.data1_o,          32'd11);
      chk("stall.alu_ctrl",  32'(bus.alu_ctrl_o),  32'b100);
      chk("stall.data2",     bus.data2_o,          32'hFFFF_FFF9);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("unstall.in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    chk("unstall.data1",    bus.data1_o,         32'd22);
    chk("unstall.alu_ctrl", 32'(bus.alu_ctrl_o), 32'b101);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;

    // flush a valid entry while ID offers another instruction
    vc = vecs[3];
    drive(vc);
    bus.flush_i = 1'b1;
    #1;
    chk("flush.in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    chk("flush.out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("flush.alu_ctrl",  32'(bus.alu_ctrl_o),  32'd0);
    chk("flush.regwrite",  32'(bus.regwrite_o),  32'd0);
    chk("flush.cnt",       32'(bus.flush_cnt_o), 32'd1);
    // flush of an empty stage leaves the counter alone
    bus.in_valid_i = 1'b0;
    tick();
    chk("flush_empty.cnt",       32'(bus.flush_cnt_o), 32'd1);
    chk("flush_empty.out_valid", 32'(bus.out_valid_o), 32'd0);
    bus.flush_i = 1'b0;

    // reset in the middle of a stall
    bus.out_ready_i = 1'b1;
    drive(va);
    tick();
    bus.out_ready_i = 1'b0;
    drive(vb);
    tick();
    chk("midstall.held", bus.data1_o, 32'd11);
    rst = 1'b1;
    tick();
    chk("midrst.out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst.data1",     bus.data1_o,          32'd0);
    chk("midrst.alu_ctrl",  32'(bus.alu_ctrl_o),  32'd0);
    chk("midrst.regwrite",  32'(bus.regwrite_o),  32'd0);
    chk("midrst.cnt",       32'(bus.flush_cnt_o), 32'd0);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    vb.rs1 = 32'd100;
    drive(vb);
    #1;
    chk("postrst.in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    chk("postrst.out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("postrst.data1",     bus.data1_o,          32'd100);
    bus.in_valid_i = 1'b0;
    tick();

    // saturation of the 2-bit flush counter
    for (int i = 0; i < 5; i++) begin
      drive(va);
      tick();
      bus.in_valid_i = 1'b0;
      bus.flush_i    = 1'b1;
      tick();
      bus.flush_i    = 1'b0;
      chk($sformatf("sat.cnt%0d", i), 32'(bus.flush_cnt_o), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    rst = 1'b1;
    tick();
    chk("sat.rst_cnt", 32'(bus.flush_cnt_o), 32'd0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
